// File: rtl/fibre_a_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fibre_a_arbiter_pkg
// Brief   : Shared helpers for the fibre_a read-port arbiter.
// Revision: 1.0
// ============================================================================
package fibre_a_arbiter_pkg;

    // Requester-id width, never narrower than one bit.
    function automatic int req_id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : fibre_a_arbiter_pkg
`default_nettype wire

// File: rtl/fibre_a_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : fibre_a_arbiter_if
// Brief   : TPPE-side request/return bus and fibre_a SRAM read port.
// Revision: 1.0
// ============================================================================
interface fibre_a_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMESTEPS  = 16
);
    logic [NUM_REQ-1:0]            req_read_en;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_flat;
    logic [TIMESTEPS-1:0]          req_data;
    logic [NUM_REQ-1:0]            req_valid;
    logic                          mem_read_en;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [TIMESTEPS-1:0]          mem_data;

    modport slave (
        input  req_read_en, req_addr_flat, mem_data,
        output req_data, req_valid, mem_read_en, mem_addr
    );

    modport master (
        output req_read_en, req_addr_flat, mem_data,
        input  req_data, req_valid, mem_read_en, mem_addr
    );
endinterface : fibre_a_arbiter_if
`default_nettype wire

// File: rtl/fibre_a_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fibre_a_arbiter_rr_arbiter
// Brief   : Combinational round-robin pick: first eligible index at/after ptr.
// Revision: 1.0
// ============================================================================
module fibre_a_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    winner_o,
    output logic               any_o
);
    int idx;

    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_o && eligible_i[idx]) begin
                any_o        = 1'b1;
                winner_o     = ID_W'(idx);
                grant_o[idx] = 1'b1;
            end
        end
    end
endmodule : fibre_a_arbiter_rr_arbiter
`default_nettype wire

// File: rtl/fibre_a_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fibre_a_arbiter
// Brief   : Round-robin share of the fibre_a SRAM read port among TPPEs, with
//           a tag pipe steering returned words. FIBRE_ARB_STATS_EN adds
//           saturating grant/wait counters.
// Revision: 1.0
// ============================================================================
module fibre_a_arbiter
    import fibre_a_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int TIMESTEPS   = 16,
    parameter int MEM_LATENCY = 1,
    parameter int STATS_WIDTH = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fibre_a_arbiter_if.slave   bus
`ifdef FIBRE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STATS_WIDTH-1:0] grant_count_flat,
    output logic [NUM_REQ*STATS_WIDTH-1:0] wait_count_flat
`endif
);
    localparam int ID_W = req_id_w(NUM_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    if (NUM_REQ < 2 || MEM_LATENCY < 1 || STATS_WIDTH < 1) begin : g_bad_params
        $error("fibre_a_arbiter: illegal parameter set");
    end

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    inflight_q, inflight_d;
    tag_t                  tag_q [0:MEM_LATENCY];
    tag_t                  tag_d;
    logic                  mem_read_en_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [NUM_REQ-1:0]    req_valid_q, req_valid_d;
    logic [TIMESTEPS-1:0]  req_data_q, req_data_d;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       winner;
    logic                  any_grant;

    assign eligible = bus.req_read_en & ~inflight_q;

    fibre_a_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .winner_o   (winner),
        .any_o      (any_grant)
    );

    always_comb begin
        ptr_d       = ptr_q;
        mem_addr_d  = mem_addr_q;
        req_valid_d = '0;
        req_data_d  = req_data_q;
        tag_d       = '{valid: any_grant, id: winner};
        // A returning requester is released here, so it re-competes next cycle.
        inflight_d  = (inflight_q & ~req_valid_q) | grant;
        if (any_grant) begin
            ptr_d      = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            mem_addr_d = bus.req_addr_flat[winner*ADDR_WIDTH +: ADDR_WIDTH];
        end
        if (tag_q[MEM_LATENCY].valid) begin
            req_valid_d = NUM_REQ'(1) << tag_q[MEM_LATENCY].id;
            req_data_d  = bus.mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            inflight_q    <= '0;
            mem_read_en_q <= 1'b0;
            mem_addr_q    <= '0;
            req_valid_q   <= '0;
            req_data_q    <= '0;
            for (int k = 0; k <= MEM_LATENCY; k++) tag_q[k] <= '0;
        end else begin
            ptr_q         <= ptr_d;
            inflight_q    <= inflight_d;
            mem_read_en_q <= any_grant;
            mem_addr_q    <= mem_addr_d;
            req_valid_q   <= req_valid_d;
            req_data_q    <= req_data_d;
            tag_q[0]      <= tag_d;
            for (int k = 1; k <= MEM_LATENCY; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign bus.mem_read_en = mem_read_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.req_valid   = req_valid_q;
    assign bus.req_data    = req_data_q;

`ifdef FIBRE_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        logic [STATS_WIDTH-1:0] grant_cnt_q;
        logic [STATS_WIDTH-1:0] wait_cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                grant_cnt_q <= '0;
                wait_cnt_q  <= '0;
            end else begin
                if (grant[i] && grant_cnt_q != '1)
                    grant_cnt_q <= grant_cnt_q + 1'b1;
                if (eligible[i] && !grant[i] && wait_cnt_q != '1)
                    wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end

        assign grant_count_flat[i*STATS_WIDTH +: STATS_WIDTH] = grant_cnt_q;
        assign wait_count_flat[i*STATS_WIDTH +: STATS_WIDTH]  = wait_cnt_q;
    end
`endif
endmodule : fibre_a_arbiter
`default_nettype wire

// File: tb/tb_fibre_a_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fibre_a_arbiter
// Brief   : Randomized bench for fibre_a_arbiter against a transaction-level
//           round-robin model (stats checked when FIBRE_ARB_STATS_EN is set).
// Revision: 1.0
// ============================================================================
module tb_fibre_a_arbiter;
    localparam int N    = 4;
    localparam int AW   = 8;
    localparam int TS   = 16;
    localparam int L    = 1;
    localparam int SW   = 4;
    localparam int MAXC = 4000;

    logic clk = 1'b0;
    logic rst_n;

    fibre_a_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .TIMESTEPS(TS)) bus ();

`ifdef FIBRE_ARB_STATS_EN
    logic [N*SW-1:0] grant_count_flat;
    logic [N*SW-1:0] wait_count_flat;
`endif

    fibre_a_arbiter #(
        .NUM_REQ     (N),
        .ADDR_WIDTH  (AW),
        .TIMESTEPS   (TS),
        .MEM_LATENCY (L),
        .STATS_WIDTH (SW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus)
`ifdef FIBRE_ARB_STATS_EN
        ,
        .grant_count_flat (grant_count_flat),
        .wait_count_flat  (wait_count_flat)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [TS-1:0] data;
        int            due;
    } pend_t;

    logic [TS-1:0] mem [0:255];
    logic          hist_en   [0:MAXC];
    logic [AW-1:0] hist_addr [0:MAXC];
    pend_t         pq [$];

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;
    int            mode  = 0;
    int            ptr   = 0;
    logic          exp_mem_en;
    logic [AW-1:0] exp_mem_addr;
    logic [N-1:0]  exp_valid;
    logic [TS-1:0] exp_data;
    int            gcnt [N];
    int            wcnt [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= (1 << SW) - 1) ? v : v + 1;
    endfunction

    task automatic model_clear();
        pq.delete();
        ptr          = 0;
        exp_mem_en   = 1'b0;
        exp_mem_addr = '0;
        exp_valid    = '0;
        exp_data     = '0;
        for (int i = 0; i < N; i++) begin
            gcnt[i] = 0;
            wcnt[i] = 0;
        end
    endtask

    // One clock: check registered outputs, drive this cycle's inputs, advance model.
    task automatic step(input bit do_rst);
        logic [N-1:0]    en;
        logic [N*AW-1:0] addrs;
        logic [N-1:0]    infl;
        logic [N-1:0]    elig;
        int              win;
        int              idx;
        @(posedge clk);
        #1;
        cyc++;
        chk("mem_read_en", 64'(bus.mem_read_en), 64'(exp_mem_en));
        chk("mem_addr", 64'(bus.mem_addr), 64'(exp_mem_addr));
        chk("req_valid", 64'(bus.req_valid), 64'(exp_valid));
        if (exp_valid != '0) chk("req_data", 64'(bus.req_data), 64'(exp_data));
`ifdef FIBRE_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            chk("grant_count", 64'(grant_count_flat[i*SW +: SW]), 64'(gcnt[i]));
            chk("wait_count", 64'(wait_count_flat[i*SW +: SW]), 64'(wcnt[i]));
        end
`endif
        hist_en[cyc]   = bus.mem_read_en;
        hist_addr[cyc] = bus.mem_addr;
        bus.mem_data   = (cyc >= L && hist_en[cyc-L]) ? mem[hist_addr[cyc-L]] : TS'($urandom);

        for (int i = 0; i < N; i++) addrs[i*AW +: AW] = AW'($urandom);
        case (mode)
            0:       en = '1;
            1: begin en = 4'b0100; addrs[2*AW +: AW] = 8'h35; end
            3:       en = {1'b1, 2'b00, cyc[0]};
            default: en = N'($urandom);
        endcase
        if (do_rst) en = '1;
        bus.req_read_en   = en;
        bus.req_addr_flat = addrs;

        if (do_rst) begin
            rst_n = 1'b0;
            model_clear();
            return;
        end
        rst_n = 1'b1;

        while (pq.size() > 0 && pq[0].due < cyc) void'(pq.pop_front());
        infl      = '0;
        exp_valid = '0;
        foreach (pq[j]) begin
            infl[pq[j].id] = 1'b1;
            if (pq[j].due == cyc + 1) begin
                exp_valid[pq[j].id] = 1'b1;
                exp_data            = pq[j].data;
            end
        end
        elig = en & ~infl;
        win  = -1;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (win < 0 && elig[idx]) win = idx;
        end
        exp_mem_en = (win >= 0);
        if (win >= 0) begin
            exp_mem_addr = addrs[win*AW +: AW];
            pq.push_back('{id: win, data: mem[addrs[win*AW +: AW]], due: cyc + 2 + L});
            ptr = (win + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (win == i)     gcnt[i] = sat(gcnt[i]);
            else if (elig[i]) wcnt[i] = sat(wcnt[i]);
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.req_read_en   = '1;
        bus.req_addr_flat = '0;
        bus.mem_data      = '0;
        for (int a = 0; a < 256; a++) mem[a] = TS'($urandom);
        mem[8'h35] = 16'hBEEF;
        model_clear();

        mode = 0;
        repeat (3)   step(1'b1);
        repeat (40)  step(1'b0);
        mode = 1;
        repeat (20)  step(1'b0);
        mode = 3;
        repeat (40)  step(1'b0);
        mode = 2;
        repeat (300) step(1'b0);
        // Reset with reads outstanding; none of them may come back.
        mode = 0;
        repeat (3)   step(1'b0);
        repeat (2)   step(1'b1);
        mode = 2;
        repeat (300) step(1'b0);
        mode = 0;
        repeat (40)  step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule : tb_fibre_a_arbiter
`default_nettype wire
